// File: rtl/arb_mux_n.sv
// N-channel registered multiplexer with valid/ready handshakes. The grant comes
// either from an external select or from round-robin arbitration.
module arb_mux_n #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MODE  = 1,
    parameter int unsigned SW    = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic [SW-1:0]         sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SW-1:0]         out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [WIDTH-1:0] ch_data [N_CH];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SW-1:0]    out_ch_q,    out_ch_d;
    logic [SW-1:0]    ptr_q,       ptr_d;

    logic             load_en;
    logic             gnt_vld;
    logic [SW-1:0]    gnt_idx;
    logic             hi_found, lo_found;
    logic [SW-1:0]    hi_idx,   lo_idx;

    for (genvar g = 0; g < N_CH; g++) begin : g_slice
        assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
    end

    assign load_en = !out_valid_q || out_ready;

    // Round-robin search: the first valid channel above ptr wins; if there is none,
    // the lowest valid channel at or below ptr wins. The search wraps at N_CH.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!hi_found && in_valid[SW'(i)] && (SW'(i) > ptr_q)) begin
                hi_found = 1'b1;
                hi_idx   = SW'(i);
            end
            if (!lo_found && in_valid[SW'(i)] && (SW'(i) <= ptr_q)) begin
                lo_found = 1'b1;
                lo_idx   = SW'(i);
            end
        end
        if (MODE == 0) begin
            // A sel value at or above N_CH matches no channel and yields no grant.
            for (int unsigned i = 0; i < N_CH; i++) begin
                if ((SW'(i) == sel) && in_valid[SW'(i)]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SW'(i);
                end
            end
        end else if (hi_found) begin
            gnt_vld = 1'b1;
            gnt_idx = hi_idx;
        end else if (lo_found) begin
            gnt_vld = 1'b1;
            gnt_idx = lo_idx;
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && load_en && gnt_vld) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    // Output register: load on grant, drop valid when idle, hold under backpressure.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            out_valid_d = gnt_vld;
            if (gnt_vld) begin
                out_data_d = ch_data[gnt_idx];
                out_ch_d   = gnt_idx;
                ptr_d      = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= SW'(N_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed and random bench for arb_mux_n. Four instances (8ch sel, 8ch RR,
// 5ch RR, 5ch sel) share stimulus and are each compared with a behavioural model.
module tb_arb_mux_n;

    localparam int NI = 4;
    localparam int N_OF [NI] = '{8, 8, 5, 5};
    localparam int MD   [NI] = '{0, 1, 1, 0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic [7:0]  in_valid;
    logic [2:0]  sel;
    logic        out_ready;

    logic [7:0]  od  [NI];
    logic [2:0]  och [NI];
    logic        ov  [NI];
    logic [7:0]  ir  [NI];
    logic [7:0]  ir_0, ir_1;
    logic [4:0]  ir_2, ir_3;

    // Behavioural model state per instance
    logic        ev   [NI];
    logic [7:0]  ed   [NI];
    int          ech  [NI];
    int          ptr  [NI];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    arb_mux_n #(.N_CH(8), .WIDTH(8), .MODE(0)) u_s8 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir_0), .sel(sel), .out_data(od[0]), .out_ch(och[0]),
        .out_valid(ov[0]), .out_ready(out_ready));
    arb_mux_n #(.N_CH(8), .WIDTH(8), .MODE(1)) u_r8 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir_1), .sel(sel), .out_data(od[1]), .out_ch(och[1]),
        .out_valid(ov[1]), .out_ready(out_ready));
    arb_mux_n #(.N_CH(5), .WIDTH(8), .MODE(1)) u_r5 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[39:0]), .in_valid(in_valid[4:0]),
        .in_ready(ir_2), .sel(sel), .out_data(od[2]), .out_ch(och[2]),
        .out_valid(ov[2]), .out_ready(out_ready));
    arb_mux_n #(.N_CH(5), .WIDTH(8), .MODE(0)) u_s5 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[39:0]), .in_valid(in_valid[4:0]),
        .in_ready(ir_3), .sel(sel), .out_data(od[3]), .out_ch(och[3]),
        .out_valid(ov[3]), .out_ready(out_ready));

    assign ir[0] = ir_0;
    assign ir[1] = ir_1;
    assign ir[2] = {3'b000, ir_2};
    assign ir[3] = {3'b000, ir_3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference grant. The select mode checks range and valid. Round robin scans
    // ptr+1, ptr+2, ... modulo the channel count.
    function automatic int model_grant(input int k);
        int n;
        n = N_OF[k];
        if (MD[k] == 0) begin
            return (int'(sel) < n && in_valid[sel]) ? int'(sel) : -1;
        end
        for (int d = 1; d <= n; d++) begin
            int c;
            c = (ptr[k] + d) % n;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            ev[k]  = 1'b0;
            ed[k]  = 8'h00;
            ech[k] = 0;
            ptr[k] = N_OF[k] - 1;
        end
    endtask

    task automatic check_outputs(input string where);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s out_valid[%0d]", where, k), 32'(ov[k]),  32'(ev[k]));
            chk($sformatf("%s out_data[%0d]", where, k),  32'(od[k]),  32'(ed[k]));
            chk($sformatf("%s out_ch[%0d]", where, k),    32'(och[k]), 32'(ech[k]));
        end
    endtask

    // One cycle: the caller drives inputs just after a negedge. This task checks
    // in_ready, advances the model at the posedge, then checks the registered outputs.
    task automatic step();
        int   g  [NI];
        logic ld [NI];
        #1;
        for (int k = 0; k < NI; k++) begin
            logic [7:0] er;
            g[k]  = model_grant(k);
            ld[k] = !ev[k] || out_ready;
            er    = 8'h00;
            if (ld[k] && g[k] >= 0) er[g[k]] = 1'b1;
            chk($sformatf("in_ready[%0d]", k), 32'(ir[k]), 32'(er));
        end
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            if (ld[k]) begin
                if (g[k] >= 0) begin
                    ev[k]  = 1'b1;
                    ed[k]  = 8'(in_data >> (g[k] * 8));
                    ech[k] = g[k];
                    ptr[k] = g[k];
                end else begin
                    ev[k] = 1'b0;
                end
            end
        end
        #1;
        check_outputs("step");
        @(negedge clk);
    endtask

    // Reset asserted asynchronously. Outputs must clear at once, before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        for (int k = 0; k < NI; k++) chk($sformatf("reset in_ready[%0d]", k), 32'(ir[k]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 8'hFF;
        sel       = 3'd0;
        out_ready = 1'b1;
        do_reset();

        // Select sweep: channel i carries 1<<i
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(1 << i);
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            step();
            chk("sel_sweep data", 32'(od[0]), 32'(1 << s));
            chk("sel_sweep ch",   32'(och[0]), 32'(s));
        end

        // Round-robin fairness: 0..7 twice, one word per cycle
        do_reset();
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(8'hA0 + i);
        for (int j = 0; j < 16; j++) begin
            step();
            chk("rr_fair ch",   32'(och[1]), 32'(j % 8));
            chk("rr_fair data", 32'(od[1]),  32'(8'hA0 + (j % 8)));
        end

        // Backpressure with channels 2 and 5 requesting
        do_reset();
        in_valid = 8'b0010_0100;
        step();
        chk("bp first ch", 32'(och[1]), 32'd2);
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("bp hold ch", 32'(och[1]), 32'd2);
        end
        out_ready = 1'b1;
        step();
        chk("bp next ch", 32'(och[1]), 32'd5);
        step();
        chk("bp wrap ch", 32'(och[1]), 32'd2);

        // Wrap on 5 channels with only channels 4 and 0 valid
        do_reset();
        in_valid = 8'b0001_0001;
        for (int j = 0; j < 4; j++) begin
            step();
            chk("wrap5 ch", 32'(och[2]), (j % 2 == 0) ? 32'd0 : 32'd4);
        end

        // Out-of-range select on the 5-channel select instance
        in_valid = 8'hFF;
        sel = 3'd1;
        step();
        sel = 3'd6;
        step();
        chk("sel_oor valid", 32'(ov[3]), 32'd0);

        // Idle: valid drops, data and channel hold
        in_valid = 8'h00;
        step();
        step();

        // Random traffic
        for (int j = 0; j < 400; j++) begin
            in_data   = {$urandom, $urandom};
            in_valid  = 8'($urandom);
            sel       = 3'($urandom);
            out_ready = ($urandom % 4) != 0;
            step();
        end

        // Reset mid-transfer while a word is held under backpressure
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        #2;
        do_reset();
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        sel       = 3'd3;
        step();
        chk("post_reset rr8 ch", 32'(och[1]), 32'd0);
        chk("post_reset rr5 ch", 32'(och[2]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
